bkt_lvl_finder: RTL and testbench

//   Backtrack-level search controller placed directly beside the 8-level state array of the Sat Engine.
//   On conflict it scans the array's findflag chain from max_lvl downward for the deepest not-yet-backtracked level.
//   It decodes the hit to an absolute level and bin number, then pulses apply_bkt to commit the backtrack.
//   It reports bkt_none when every level in the window is already backtracked, so the outer control can move to the previous bin or declare UNSAT.

---
 rtl/sat_engine_pkg.sv | 18 +
 rtl/onehot8_enc.sv | 20 ++
 rtl/bkt_lvl_finder.sv | 169 ++++++++++++++++
 tb/tb_bkt_lvl_finder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sat_engine_pkg.sv
// Shared types and constants for the Sat Engine backtrack controller.
// Holds the findflag chain encodings and the backtrack-search FSM state type.
package sat_engine_pkg;

    localparam logic [1:0] FIND_NONE = 2'd0;
    localparam logic [1:0] FIND_HIT  = 2'd1;
    localparam logic [1:0] FIND_PAST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_WAIT,
        ST_DECODE,
        ST_APPLY,
        ST_FIN
    } bkt_state_t;

endpackage

// File: rtl/onehot8_enc.sv
// 8-bit one-hot to 3-bit index encoder.
// A vector that is not one-hot encodes its highest set bit, with onehot_ok low.
module onehot8_enc (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       onehot_ok
);

    always_comb begin
        idx = '0;
        // Ascending scan: the last set bit seen, i.e. the highest, wins.
        for (int unsigned i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        onehot_ok = (vec != '0) && ((vec & (vec - 8'd1)) == '0);
    end

endmodule

// File: rtl/bkt_lvl_finder.sv
// Backtrack-level search controller beside the 8-level state array.
// Seeds the findflag chain, waits for it to settle, decodes the hit and pulses apply.
import sat_engine_pkg::*;

module bkt_lvl_finder #(
    parameter int NUM_LVLS   = 8,
    parameter int WIDTH_LVL  = 16,
    parameter int WIDTH_BIN  = 10,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH_LVL-1:0] max_lvl_i,
    input  logic [WIDTH_LVL-1:0] base_lvl_i,
    output logic [1:0]           findflag_o,
    output logic [WIDTH_LVL-1:0] max_lvl_o,
    input  logic [1:0]           findflag_i,
    input  logic [7:0]           findindex_i,
    input  logic [WIDTH_BIN-1:0] bkt_bin_i,
    output logic                 apply_bkt_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic [WIDTH_BIN-1:0] bkt_bin_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 bkt_none_o,
    output logic                 err_o
);

    localparam int CW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [7:0] SLOT_MASK = 8'((1 << NUM_LVLS) - 1);

    bkt_state_t           state;
    bkt_state_t           state_nx;
    logic [CW-1:0]        cnt;
    logic [WIDTH_LVL-1:0] base_q;
    logic                 none_q;

    logic                 accept;
    logic                 early_none;
    logic                 hit;
    logic                 hit_valid;
    logic [7:0]           slots;
    logic [2:0]           idx;
    logic                 onehot_ok;

    logic                 take_hit;
    logic                 miss_none;
    logic                 set_err;
    logic                 fire_apply;
    logic                 finish;

    // The chain seed is always "searching"; the array only looks at it while max_lvl_o is live.
    assign findflag_o = FIND_NONE;

    // done_o is registered, so the IDLE cycle it occupies must not accept a new start.
    assign accept     = (state == ST_IDLE) && start_i && !done_o;
    assign early_none = (max_lvl_i == '0) || (max_lvl_i < base_lvl_i);
    assign hit        = (findflag_i == FIND_HIT) || (findflag_i == FIND_PAST);
    assign slots      = findindex_i & SLOT_MASK;
    assign hit_valid  = hit && (slots != '0);

    onehot8_enc u_enc (
        .vec       (slots),
        .idx       (idx),
        .onehot_ok (onehot_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = early_none ? ST_FIN : ST_SEED;
                end
            end
            // SEED counts as the first settle cycle, so WAIT spans SETTLE_CYC-1 cycles.
            ST_SEED:   state_nx = (SETTLE_CYC <= 1) ? ST_DECODE : ST_WAIT;
            ST_WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: state_nx = hit_valid ? ST_APPLY : ST_FIN;
            ST_APPLY:  state_nx = ST_FIN;
            ST_FIN:    state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        take_hit   = 1'b0;
        miss_none  = 1'b0;
        set_err    = 1'b0;
        fire_apply = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_DECODE: begin
                take_hit  = hit_valid;
                miss_none = !hit_valid;
                set_err   = hit && !onehot_ok;
            end
            ST_APPLY: fire_apply = 1'b1;
            ST_FIN:   finish     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_SEED) begin
            cnt <= CW'(SETTLE_CYC - 1);
        end else if (state == ST_WAIT) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            none_q      <= 1'b0;
            max_lvl_o   <= '0;
            apply_bkt_o <= 1'b0;
            bkt_lvl_o   <= '0;
            bkt_bin_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bkt_none_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            apply_bkt_o <= fire_apply;
            done_o      <= finish;
            bkt_none_o  <= finish && none_q;
            if (accept) begin
                base_q <= base_lvl_i;
                none_q <= early_none;
                busy_o <= 1'b1;
                err_o  <= 1'b0;
                if (!early_none) begin
                    max_lvl_o <= max_lvl_i;
                end
            end
            if (miss_none) begin
                none_q <= 1'b1;
            end
            if (take_hit) begin
                bkt_lvl_o <= base_q + WIDTH_LVL'(idx);
                bkt_bin_o <= bkt_bin_i;
            end
            if (set_err) begin
                err_o <= 1'b1;
            end
            if (finish) begin
                busy_o    <= 1'b0;
                max_lvl_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bkt_lvl_finder.sv
// Directed bench for bkt_lvl_finder: a vector table of single searches plus
// hand-written reset-in-WAIT and back-to-back sequences.
module tb_bkt_lvl_finder;
    import sat_engine_pkg::*;

    localparam int S  = 2;
    localparam int WL = 16;
    localparam int WB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [WL-1:0] max_lvl_i;
    logic [WL-1:0] base_lvl_i;
    logic [1:0]    findflag_o;
    logic [WL-1:0] max_lvl_o;
    logic [1:0]    findflag_i;
    logic [7:0]    findindex_i;
    logic [WB-1:0] bkt_bin_i;
    logic          apply_bkt_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [WB-1:0] bkt_bin_o;
    logic          busy_o;
    logic          done_o;
    logic          bkt_none_o;
    logic          err_o;

    bkt_lvl_finder #(
        .NUM_LVLS   (8),
        .WIDTH_LVL  (WL),
        .WIDTH_BIN  (WB),
        .SETTLE_CYC (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .max_lvl_i   (max_lvl_i),
        .base_lvl_i  (base_lvl_i),
        .findflag_o  (findflag_o),
        .max_lvl_o   (max_lvl_o),
        .findflag_i  (findflag_i),
        .findindex_i (findindex_i),
        .bkt_bin_i   (bkt_bin_i),
        .apply_bkt_o (apply_bkt_o),
        .bkt_lvl_o   (bkt_lvl_o),
        .bkt_bin_o   (bkt_bin_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bkt_none_o  (bkt_none_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WL-1:0] max;
        logic [WL-1:0] base;
        logic [1:0]    ff;
        logic [7:0]    idx;
        logic [WB-1:0] bin;
        logic [WL-1:0] e_lvl;
        logic [WB-1:0] e_bin;
        logic          e_none;
        logic          e_err;
        int            e_app;
        int            e_lat;
        logic [WL-1:0] e_mo;
    } vec_t;

    typedef struct {
        int            lat;
        int            apps;
        logic [WL-1:0] mo;
        logic          busy_d;
        logic          none_d;
        logic          err_d;
    } res_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_search(input vec_t v, output res_t r);
        @(negedge clk);
        max_lvl_i   = v.max;
        base_lvl_i  = v.base;
        findflag_i  = v.ff;
        findindex_i = v.idx;
        bkt_bin_i   = v.bin;
        start_i     = 1'b1;
        r.lat = 0; r.apps = 0; r.mo = '0;
        r.busy_d = 1'b1; r.none_d = 1'b0; r.err_d = 1'b0;
        for (int c = 1; c <= 40 && r.lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_i = 1'b0;
                r.mo = max_lvl_o;
            end
            if (apply_bkt_o) r.apps++;
            if (done_o) begin
                r.lat    = c;
                r.busy_d = busy_o;
                r.none_d = bkt_none_o;
                r.err_d  = err_o;
            end
        end
        @(negedge clk);
        if (apply_bkt_o) r.apps++;
    endtask

    initial begin
        res_t r;
        int   apps;
        int   nd;
        int   d[3];

        //            max      base     ff  idx     bin  e_lvl  e_bin none err app lat   e_mo
        vecs[0] = '{16'd21,  16'd16,  2'd1, 8'h20, 10'd7,   16'd21, 10'd7,   1'b0, 1'b0, 1, S+4, 16'd21};
        vecs[1] = '{16'd30,  16'd24,  2'd0, 8'h00, 10'd0,   16'd21, 10'd7,   1'b1, 1'b0, 0, S+3, 16'd30};
        vecs[2] = '{16'd0,   16'd0,   2'd1, 8'h01, 10'd5,   16'd21, 10'd7,   1'b1, 1'b0, 0, 2,   16'd0};
        vecs[3] = '{16'd5,   16'd10,  2'd1, 8'h01, 10'd5,   16'd21, 10'd7,   1'b1, 1'b0, 0, 2,   16'd0};
        vecs[4] = '{16'd200, 16'd100, 2'd1, 8'h44, 10'd9,   16'd106, 10'd9,  1'b0, 1'b1, 1, S+4, 16'd200};
        vecs[5] = '{16'd40,  16'd40,  2'd2, 8'h01, 10'd3,   16'd40, 10'd3,   1'b0, 1'b0, 1, S+4, 16'd40};
        vecs[6] = '{16'hFFFF, 16'hFFFE, 2'd1, 8'h08, 10'd1023, 16'd1, 10'd1023, 1'b0, 1'b0, 1, S+4, 16'hFFFF};
        vecs[7] = '{16'd50,  16'd48,  2'd1, 8'h00, 10'd5,   16'd1,  10'd1023, 1'b1, 1'b1, 0, S+3, 16'd50};
        vecs[8] = '{16'd57,  16'd50,  2'd2, 8'h80, 10'd12,  16'd57, 10'd12,  1'b0, 1'b0, 1, S+4, 16'd57};

        rst = 1'b1; start_i = 1'b0; max_lvl_i = '0; base_lvl_i = '0;
        findflag_i = '0; findindex_i = '0; bkt_bin_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_apply", 32'(apply_bkt_o), 0);
        chk("rst_done",  32'(done_o), 0);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_none",  32'(bkt_none_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_lvl",   32'(bkt_lvl_o), 0);
        chk("rst_maxo",  32'(max_lvl_o), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_search(vecs[i], r);
            chk($sformatf("v%0d_lat", i),  32'(r.lat), 32'(vecs[i].e_lat));
            chk($sformatf("v%0d_app", i),  32'(r.apps), 32'(vecs[i].e_app));
            chk($sformatf("v%0d_maxo", i), 32'(r.mo), 32'(vecs[i].e_mo));
            chk($sformatf("v%0d_busy", i), 32'(r.busy_d), 0);
            chk($sformatf("v%0d_none", i), 32'(r.none_d), 32'(vecs[i].e_none));
            chk($sformatf("v%0d_err", i),  32'(r.err_d), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_lvl", i),  32'(bkt_lvl_o), 32'(vecs[i].e_lvl));
            chk($sformatf("v%0d_bin", i),  32'(bkt_bin_o), 32'(vecs[i].e_bin));
        end

        // Reset while in WAIT: outputs clear immediately and no apply ever appears.
        @(negedge clk);
        max_lvl_i = 16'd20; base_lvl_i = 16'd16; findflag_i = 2'd1;
        findindex_i = 8'h02; bkt_bin_i = 10'd9; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("seed_flag", 32'(findflag_o), 32'(FIND_NONE));
        chk("seed_busy", 32'(busy_o), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wrst_busy", 32'(busy_o), 0);
        chk("wrst_maxo", 32'(max_lvl_o), 0);
        chk("wrst_lvl",  32'(bkt_lvl_o), 0);
        chk("wrst_bin",  32'(bkt_bin_o), 0);
        chk("wrst_done", 32'(done_o), 0);
        apps = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (apply_bkt_o) apps++;
        end
        chk("wrst_noapply", 32'(apps), 0);
        run_search('{16'd20, 16'd16, 2'd1, 8'h02, 10'd9, 16'd17, 10'd9, 1'b0, 1'b0, 1, S+4, 16'd20}, r);
        chk("post_rst_lat", 32'(r.lat), S+4);
        chk("post_rst_app", 32'(r.apps), 1);
        chk("post_rst_lvl", 32'(bkt_lvl_o), 17);

        // Back-to-back: start held high, one search per S+5 cycles.
        @(negedge clk);
        max_lvl_i = 16'd63; base_lvl_i = 16'd60; findflag_i = 2'd1;
        findindex_i = 8'h08; bkt_bin_i = 10'd4; start_i = 1'b1;
        apps = 0; nd = 0; d = '{0, 0, 0};
        for (int c = 1; c <= 60 && nd < 3; c++) begin
            @(negedge clk);
            if (apply_bkt_o) apps++;
            if (done_o) begin
                d[nd] = c;
                nd++;
            end
        end
        start_i = 1'b0;
        chk("b2b_ndone", 32'(nd), 3);
        chk("b2b_first", 32'(d[0]), S+4);
        chk("b2b_gap1",  32'(d[1] - d[0]), S+5);
        chk("b2b_gap2",  32'(d[2] - d[1]), S+5);
        repeat (4) begin
            @(negedge clk);
            if (apply_bkt_o) apps++;
        end
        chk("b2b_apps", 32'(apps), 3);
        chk("b2b_idle", 32'(busy_o), 0);
        chk("b2b_lvl",  32'(bkt_lvl_o), 63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
